reg_milestone_checker: RTL
==========================

Name: reg_milestone_checker

Overview:
Synthesisable on-chip checker that snoops the Riscv151 register-file writeback port and keeps a shadow copy of the architectural registers. It holds a programmable table of milestone checks: (flag value, register, expected value). When a designated flag register reaches each milestone, it compares the listed registers and reports pass/fail/timeout. It generalises the per-test directed register checks to a parametrised, hardware-resident scoreboard usable in simulation and on FPGA.

Parameters:
XLEN, 32, datapath and register width
NUM_CHECKS, 16, check-table depth (power of 2, >=2)
FLAG_REG, 20, architectural register used as the milestone flag
TIMEOUT_CYCLES, 1000, cycles allowed from start to done
IDX_W, $clog2(NUM_CHECKS), table index width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
wb_en  in  1  regfile write strobe from CPU
wb_addr  in  5  regfile write address
wb_data  in  XLEN  regfile write data
tbl_we  in  1  table write strobe (accepted only in IDLE)
tbl_idx  in  IDX_W  table entry index
tbl_flag  in  XLEN  milestone flag value for the entry
tbl_reg  in  5  register to compare
tbl_val  in  XLEN  expected value
num_checks  in  IDX_W+1  entries in use (1..NUM_CHECKS), sampled on start
start  in  1  single-cycle pulse: IDLE -> WAIT
busy  out  1  high in WAIT/CHECK
done  out  1  sticky; high in DONE/FAIL/TIMEOUT
pass  out  1  sticky; done with zero failures and no timeout
timeout  out  1  sticky; timeout counter expired
fail_cnt  out  IDX_W+1  number of mismatching entries
fail_idx  out  IDX_W  index of first mismatch
fail_got  out  XLEN  shadow value seen at first mismatch
chk_idx  out  IDX_W+1  current entry pointer

Behaviour:
- Reset (rst=0, async): FSM=IDLE; all outputs 0; shadow regs 0; table entries 0; counters 0.
- Shadow: on posedge with wb_en=1 and wb_addr!=0, shadow[wb_addr]<=wb_data; writes to x0 ignored; shadow[0] is always 0. Shadow updates in every state, including IDLE.
- States: IDLE, WAIT, CHECK, DONE, FAIL, TIMEOUT.
- IDLE:
  - tbl_we writes the entry.
  - start latches num_checks (0 is treated as 1), clears chk_idx, fail_cnt and the timer, and clears sticky outputs; next state WAIT.
  - tbl_we outside IDLE is ignored.
- WAIT: when shadow[FLAG_REG] == table[chk_idx].flag (level compare on the registered shadow, one cycle after the write), go to CHECK.
- CHECK:
  - One entry is evaluated per cycle: compare shadow[entry.reg] against entry.val.
  - On mismatch: fail_cnt++. The first mismatch also records fail_idx and fail_got.
  - Then chk_idx++.
  - If chk_idx+1 == num_checks: go to DONE.
  - Else if the next entry's flag equals the current entry's flag: stay in CHECK.
  - Else: go to WAIT.
  - A writeback in the same cycle as an evaluation is not visible until the next cycle.
- Timer: counts every cycle in WAIT/CHECK. At TIMEOUT_CYCLES it goes to TIMEOUT: timeout=1, done=1, pass=0. A timeout takes priority over a same-cycle DONE transition.
- DONE: done=1; pass=(fail_cnt==0). DONE, FAIL and TIMEOUT all return to IDLE only on start (re-arm) or on reset.
- fail_cnt saturates at NUM_CHECKS.
- start while busy is ignored. Reset mid-operation aborts immediately with no residual state.

Optional Feature:
CHKR_STOP_ON_FAIL_EN:
- Defined: the first mismatch moves CHECK -> FAIL; done=1, pass=0, fail_cnt=1; no further entries are evaluated.
- Undefined: mismatches are counted and the checker continues through all entries to DONE; FAIL is unreachable.

Decomposition:
- Package chkr_pkg:
  - state enum (IDLE, WAIT, CHECK, DONE, FAIL, TIMEOUT)
  - check-entry struct {flag, reg, val}
  - REG_ADDR_W=5 and X0 constants
- Natural sub-module: chkr_shadow_rf (32xXLEN shadow register file, write port, one async read port, with x0 hardwired to 0). The FSM and table stay in the top.

Test Plan:
1. Program entries {2,x1,500}, {2,x2,100}, {3,x2,111}; num_checks=3; start. Drive wb x1=500, x2=100, x20=2, then x2=111, x20=3 -> done=1, pass=1, fail_cnt=0; DONE reached within 2 cycles of the x20=3 write.
2. Same table, but drive x2=99 before x20=2 -> without CHKR_STOP_ON_FAIL_EN: done=1, pass=0, fail_cnt=1, fail_idx=1, fail_got=99. With it: FAIL state, no evaluation of entry 2.
3. Program {9,x1,32'h80000000}; flag never written -> timeout=1, done=1, pass=0 exactly TIMEOUT_CYCLES=1000 cycles after start.
4. Write x0=5, then check {1,x0,0} with x20=1 -> pass=1; shadow[0] reads 0.
5. Assert rst low during CHECK with fail_cnt=1 -> all outputs 0 asynchronously; after release, FSM is IDLE and tbl_we is accepted.
6. num_checks=NUM_CHECKS=16, all entries sharing flag 7 -> 16 consecutive CHECK cycles after x20=7, chk_idx wraps cleanly, done=1.

Source files
------------

// File: rtl/chkr_pkg.sv
// Shared types and constants for the register milestone checker.
// Optional build macro CHKR_STOP_ON_FAIL_EN is consumed by reg_milestone_checker.
package chkr_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = '0;
    localparam int CHKR_XLEN = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE,
        ST_FAIL,
        ST_TIMEOUT
    } state_t;

    // Table field widths follow CHKR_XLEN; the top's XLEN must match it.
    typedef struct packed {
        logic [CHKR_XLEN-1:0]  flag;
        logic [REG_ADDR_W-1:0] rnum;
        logic [CHKR_XLEN-1:0]  val;
    } chk_entry_t;

endpackage

// File: rtl/chkr_shadow_rf.sv
// Shadow copy of the 32-entry architectural register file, fed from the
// CPU writeback port; x0 is hardwired to zero.
module chkr_shadow_rf
    import chkr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [XLEN-1:0]       i_wdata,
    input  logic [REG_ADDR_W-1:0] i_raddr,
    output logic [XLEN-1:0]       o_rdata
);

    logic [XLEN-1:0] r_regs [32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != X0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = (i_raddr == X0) ? '0 : r_regs[i_raddr];

endmodule

// File: rtl/reg_milestone_checker.sv
// Milestone scoreboard: waits for the flag register to hit each table entry's
// flag, then compares shadow registers. Macro CHKR_STOP_ON_FAIL_EN halts on first mismatch.
module reg_milestone_checker
    import chkr_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NUM_CHECKS     = 16,
    parameter int FLAG_REG       = 20,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int IDX_W          = $clog2(NUM_CHECKS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  tbl_we,
    input  logic [IDX_W-1:0]      tbl_idx,
    input  logic [XLEN-1:0]       tbl_flag,
    input  logic [REG_ADDR_W-1:0] tbl_reg,
    input  logic [XLEN-1:0]       tbl_val,
    input  logic [IDX_W:0]        num_checks,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [IDX_W:0]        fail_cnt,
    output logic [IDX_W-1:0]      fail_idx,
    output logic [XLEN-1:0]       fail_got,
    output logic [IDX_W:0]        chk_idx
);

    localparam int CNT_W = IDX_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [REG_ADDR_W-1:0] FLAG_ADDR = REG_ADDR_W'(FLAG_REG);

    state_t             r_state;
    state_t             w_next_state;
    chk_entry_t         r_table [NUM_CHECKS];
    logic [CNT_W-1:0]   r_num;
    logic [CNT_W-1:0]   r_chk_idx;
    logic [CNT_W-1:0]   r_fail_cnt;
    logic [IDX_W-1:0]   r_fail_idx;
    logic [XLEN-1:0]    r_fail_got;
    logic [TMR_W-1:0]   r_timer;

    chk_entry_t              w_cur;
    logic [IDX_W-1:0]        w_nxt_idx;
    logic [REG_ADDR_W-1:0]   w_rd_addr;
    logic [XLEN-1:0]         w_rd_data;
    logic                    w_busy;
    logic                    w_tmo;
    logic                    w_eval;
    logic                    w_mismatch;
    logic                    w_last;
    logic                    w_same_flag;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_W'(NUM_CHECKS)) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] clamp_num(input logic [CNT_W-1:0] n);
        if (n == '0)
            return CNT_W'(1);
        if (n > CNT_W'(NUM_CHECKS))
            return CNT_W'(NUM_CHECKS);
        return n;
    endfunction

    // One read port is enough: WAIT only looks at the flag, CHECK only at the entry register.
    assign w_cur       = r_table[r_chk_idx[IDX_W-1:0]];
    assign w_nxt_idx   = r_chk_idx[IDX_W-1:0] + IDX_W'(1);
    assign w_same_flag = (r_table[w_nxt_idx].flag == w_cur.flag);
    assign w_rd_addr   = (r_state == ST_CHECK) ? w_cur.rnum : FLAG_ADDR;

    chkr_shadow_rf #(
        .XLEN(XLEN)
    ) u_shadow (
        .clk     (clk),
        .rst     (rst),
        .i_we    (wb_en),
        .i_waddr (wb_addr),
        .i_wdata (wb_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    assign w_busy     = (r_state == ST_WAIT) || (r_state == ST_CHECK);
    assign w_tmo      = w_busy && (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign w_eval     = (r_state == ST_CHECK) && !w_tmo;
    assign w_mismatch = (w_rd_data != w_cur.val);
    assign w_last     = ((r_chk_idx + CNT_W'(1)) == r_num);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:
                if (start) w_next_state = ST_WAIT;
            ST_WAIT:
                if (w_tmo)                        w_next_state = ST_TIMEOUT;
                else if (w_rd_data == w_cur.flag) w_next_state = ST_CHECK;
            ST_CHECK:
                if (w_tmo)            w_next_state = ST_TIMEOUT;
`ifdef CHKR_STOP_ON_FAIL_EN
                else if (w_mismatch)  w_next_state = ST_FAIL;
`endif
                else if (w_last)      w_next_state = ST_DONE;
                else if (!w_same_flag) w_next_state = ST_WAIT;
            ST_DONE, ST_FAIL, ST_TIMEOUT:
                if (start) w_next_state = ST_IDLE;
            default:
                w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                r_table[i] <= '0;
            end
            r_num      <= '0;
            r_chk_idx  <= '0;
            r_fail_cnt <= '0;
            r_fail_idx <= '0;
            r_fail_got <= '0;
            r_timer    <= '0;
        end else begin
            if ((r_state == ST_IDLE) && tbl_we) begin
                r_table[tbl_idx] <= '{flag: tbl_flag, rnum: tbl_reg, val: tbl_val};
            end
            if ((r_state == ST_IDLE) && start) begin
                r_num      <= clamp_num(num_checks);
                r_chk_idx  <= '0;
                r_fail_cnt <= '0;
                r_fail_idx <= '0;
                r_fail_got <= '0;
                r_timer    <= '0;
            end else begin
                if (w_busy) begin
                    r_timer <= r_timer + TMR_W'(1);
                end
                if (w_eval) begin
                    r_chk_idx <= r_chk_idx + CNT_W'(1);
                    if (w_mismatch) begin
                        r_fail_cnt <= sat_inc(r_fail_cnt);
                        if (r_fail_cnt == '0) begin
                            r_fail_idx <= r_chk_idx[IDX_W-1:0];
                            r_fail_got <= w_rd_data;
                        end
                    end
                end
            end
        end
    end

    assign busy     = w_busy;
    assign done     = (r_state == ST_DONE) || (r_state == ST_FAIL) || (r_state == ST_TIMEOUT);
    assign pass     = (r_state == ST_DONE) && (r_fail_cnt == '0);
    assign timeout  = (r_state == ST_TIMEOUT);
    assign fail_cnt = r_fail_cnt;
    assign fail_idx = r_fail_idx;
    assign fail_got = r_fail_got;
    assign chk_idx  = r_chk_idx;

endmodule
